// File: rtl/ro_config_sweeper.sv
// ---------------------------------------------------------------------------
// ro_config_sweeper
//
// Searches the stage-select space of two matched ring oscillators (A and B)
// for a configuration whose coherent-sampling beat count falls inside an
// acceptance window. The configuration index idx is walked from 0 upward.
// For each idx the rings are given SETTLE_CYC cycles to settle. One
// measurement is then requested, and the returned count is checked against
// [cnt_min, cnt_max]. The first accepted idx is held (locked). If every idx
// is rejected, the sweep ends in fail with the all-ones idx held.
//
// Ports
//   clk         single clock
//   rst         synchronous, active-high reset
//   start       single-cycle sweep request (ignored while busy)
//   meas_cnt    count from the coherent-sampling counter
//   meas_done   single-cycle pulse; meas_cnt is valid in the same cycle
//   cnt_min     inclusive lower bound of the acceptance window
//   cnt_max     inclusive upper bound of the acceptance window
//   sel_a       ring A stage selects (stage k on bits [2k+1:2k]) = idx low half
//   sel_b       ring B stage selects = idx high half
//   meas_start  single-cycle measurement request (first cycle of MEAS)
//   result_cnt  last captured count (all-ones after a measurement timeout)
//   busy        sweep in progress
//   locked      accepted configuration is held
//   fail        whole space exhausted without acceptance
// ---------------------------------------------------------------------------
module ro_config_sweeper #(
   parameter int NSTAGES     = 3,
   parameter int CNT_W       = 16,
   parameter int SETTLE_CYC  = 16,
   parameter int TIMEOUT_CYC = 65535
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [CNT_W-1:0]       meas_cnt,
   input  logic                   meas_done,
   input  logic [CNT_W-1:0]       cnt_min,
   input  logic [CNT_W-1:0]       cnt_max,
   output logic [2*NSTAGES-1:0]   sel_a,
   output logic [2*NSTAGES-1:0]   sel_b,
   output logic                   meas_start,
   output logic [CNT_W-1:0]       result_cnt,
   output logic                   busy,
   output logic                   locked,
   output logic                   fail
);

   localparam int SEL_W = 2 * NSTAGES;
   localparam int IDX_W = 4 * NSTAGES;
   localparam int SET_W = (SETTLE_CYC  > 1) ? $clog2(SETTLE_CYC + 1)  : 1;
   localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

   // Terminal values of the settle and timeout counters: a counter that
   // starts at 0 and stops at N-1 spans exactly N cycles.
   localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYC - 1);
   localparam logic [TMO_W-1:0] TMO_LAST    = TMO_W'(TIMEOUT_CYC - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_APPLY,
      S_MEAS,
      S_EVAL,
      S_LOCK,
      S_FAIL
   } state_t;

   state_t             state_q,      state_d;
   logic [IDX_W-1:0]   idx_q,        idx_d;
   logic [SET_W-1:0]   settle_q,     settle_d;
   logic [TMO_W-1:0]   tmo_q,        tmo_d;
   logic               timeout_q,    timeout_d;
   logic               meas_start_q, meas_start_d;
   logic [CNT_W-1:0]   result_q,     result_d;
   logic               busy_q,       busy_d;
   logic               locked_q,     locked_d;
   logic               fail_q,       fail_d;

   // Unsigned inclusive window test. An inverted window (lo > hi) cannot
   // satisfy both bounds, so it naturally accepts nothing.
   function automatic logic in_window(input logic [CNT_W-1:0] val,
                                      input logic [CNT_W-1:0] lo,
                                      input logic [CNT_W-1:0] hi);
      return (val >= lo) && (val <= hi);
   endfunction

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      settle_d     = settle_q;
      tmo_d        = tmo_q;
      timeout_d    = timeout_q;
      meas_start_d = 1'b0;
      result_d     = result_q;
      busy_d       = busy_q;
      locked_d     = locked_q;
      fail_d       = fail_q;

      case (state_q)
         S_IDLE, S_LOCK, S_FAIL: begin
            if (start) begin
               state_d   = S_APPLY;
               idx_d     = '0;
               settle_d  = '0;
               tmo_d     = '0;
               timeout_d = 1'b0;
               locked_d  = 1'b0;
               fail_d    = 1'b0;
               busy_d    = 1'b1;
            end
         end

         S_APPLY: begin
            if (settle_q == SETTLE_LAST) begin
               // meas_start is registered, so it rises with the first MEAS cycle.
               state_d      = S_MEAS;
               settle_d     = '0;
               tmo_d        = '0;
               meas_start_d = 1'b1;
            end else begin
               settle_d = settle_q + SET_W'(1);
            end
         end

         S_MEAS: begin
            if (meas_done) begin
               result_d  = meas_cnt;
               timeout_d = 1'b0;
               state_d   = S_EVAL;
            end else if (tmo_q == TMO_LAST) begin
               result_d  = '1;
               timeout_d = 1'b1;
               state_d   = S_EVAL;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end

         S_EVAL: begin
            if (!timeout_q && in_window(result_q, cnt_min, cnt_max)) begin
               state_d  = S_LOCK;
               locked_d = 1'b1;
               busy_d   = 1'b0;
            end else if (&idx_q) begin
               // Last configuration rejected: stop here rather than wrap to 0.
               state_d = S_FAIL;
               fail_d  = 1'b1;
               busy_d  = 1'b0;
            end else begin
               state_d  = S_APPLY;
               idx_d    = idx_q + IDX_W'(1);
               settle_d = '0;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         idx_q        <= '0;
         settle_q     <= '0;
         tmo_q        <= '0;
         timeout_q    <= 1'b0;
         meas_start_q <= 1'b0;
         result_q     <= '0;
         busy_q       <= 1'b0;
         locked_q     <= 1'b0;
         fail_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         settle_q     <= settle_d;
         tmo_q        <= tmo_d;
         timeout_q    <= timeout_d;
         meas_start_q <= meas_start_d;
         result_q     <= result_d;
         busy_q       <= busy_d;
         locked_q     <= locked_d;
         fail_q       <= fail_d;
      end
   end

   // idx_q is a register, so the selects come straight from flops.
   assign sel_a      = idx_q[SEL_W-1:0];
   assign sel_b      = idx_q[IDX_W-1:SEL_W];
   assign meas_start = meas_start_q;
   assign result_cnt = result_q;
   assign busy       = busy_q;
   assign locked     = locked_q;
   assign fail       = fail_q;

endmodule

// File: tb/tb_ro_config_sweeper.sv
// ---------------------------------------------------------------------------
// tb_ro_config_sweeper
//
// Directed bench for ro_config_sweeper with NSTAGES=1, SETTLE_CYC=4 and
// TIMEOUT_CYC=8. A responder process answers each meas_start two cycles
// later with a per-idx count taken from a table, or stays silent for idx
// entries that are switched off. A monitor counts meas_start pulses and
// flags any pulse that comes less than 4 cycles after a select change.
// ---------------------------------------------------------------------------
module tb_ro_config_sweeper;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] meas_cnt;
   logic        meas_done;
   logic [15:0] cnt_min;
   logic [15:0] cnt_max;
   logic [1:0]  sel_a;
   logic [1:0]  sel_b;
   logic        meas_start;
   logic [15:0] result_cnt;
   logic        busy;
   logic        locked;
   logic        fail;

   int n_cmp = 0;
   int n_err = 0;

   logic [15:0] resp_val [16];
   bit          resp_on  [16];

   int         cyc       = 0;
   int         pulse_cnt = 0;
   int         gap_viol  = 0;
   int         chg_cyc   = 0;
   logic [3:0] prev_sel  = '0;

   ro_config_sweeper #(
      .NSTAGES    (1),
      .CNT_W      (16),
      .SETTLE_CYC (4),
      .TIMEOUT_CYC(8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .meas_cnt   (meas_cnt),
      .meas_done  (meas_done),
      .cnt_min    (cnt_min),
      .cnt_max    (cnt_max),
      .sel_a      (sel_a),
      .sel_b      (sel_b),
      .meas_start (meas_start),
      .result_cnt (result_cnt),
      .busy       (busy),
      .locked     (locked),
      .fail       (fail)
   );

   always #5 clk = ~clk;

   // Pulse counter and settle-gap monitor.
   always @(posedge clk) begin
      cyc      <= cyc + 1;
      prev_sel <= {sel_b, sel_a};
      if ({sel_b, sel_a} != prev_sel) chg_cyc <= cyc;
      if (meas_start) begin
         pulse_cnt <= pulse_cnt + 1;
         if (cyc - chg_cyc < 4) gap_viol <= gap_viol + 1;
      end
   end

   // Measurement responder: answers two cycles after meas_start.
   initial begin
      logic [15:0] v;
      meas_done = 1'b0;
      meas_cnt  = '0;
      forever begin
         @(posedge clk); #1;
         if (meas_start && resp_on[{sel_b, sel_a}]) begin
            v = resp_val[{sel_b, sel_a}];
            @(posedge clk); #1;
            meas_done = 1'b1;
            meas_cnt  = v;
            @(posedge clk); #1;
            meas_done = 1'b0;
            meas_cnt  = '0;
         end
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_resp(input logic [15:0] v_lo, input logic [15:0] v_hi, input int split);
      for (int i = 0; i < 16; i++) begin
         resp_val[i] = (i < split) ? v_lo : v_hi;
         resp_on[i]  = 1'b1;
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int lim);
      int k;
      k = 0;
      while (busy && k < lim) begin
         tick();
         k++;
      end
      chk(tag, 32'(busy), 32'd0);
   endtask

   task automatic wait_mstart(input string tag, input int lim);
      int k;
      k = 0;
      while (!meas_start && k < lim) begin
         tick();
         k++;
      end
      chk(tag, 32'(meas_start), 32'd1);
   endtask

   initial begin
      int p0;
      int g0;
      int k;

      rst     = 1'b1;
      start   = 1'b0;
      cnt_min = 16'd100;
      cnt_max = 16'd120;
      set_resp(16'd110, 16'd110, 0);
      tick(3);

      // Reset state.
      chk("rst_sel_a",      32'(sel_a),      32'd0);
      chk("rst_sel_b",      32'(sel_b),      32'd0);
      chk("rst_meas_start", 32'(meas_start), 32'd0);
      chk("rst_busy",       32'(busy),       32'd0);
      chk("rst_locked",     32'(locked),     32'd0);
      chk("rst_fail",       32'(fail),       32'd0);
      chk("rst_result",     32'(result_cnt), 32'd0);
      rst = 1'b0;
      tick();

      // First hit at idx 0.
      p0 = pulse_cnt;
      pulse_start();
      chk("s1_busy",        32'(busy),       32'd1);
      tick(3);
      chk("s1_settle",      32'(meas_start), 32'd0);
      tick();
      chk("s1_mstart",      32'(meas_start), 32'd1);
      tick();
      chk("s1_mstart_once", 32'(meas_start), 32'd0);
      wait_idle("s1_idle", 100);
      chk("s1_locked",      32'(locked),     32'd1);
      chk("s1_fail",        32'(fail),       32'd0);
      chk("s1_sel_a",       32'(sel_a),      32'd0);
      chk("s1_sel_b",       32'(sel_b),      32'd0);
      chk("s1_result",      32'(result_cnt), 32'd110);
      chk("s1_pulses",      32'(pulse_cnt - p0), 32'd1);

      // Mid-sweep hit at idx 7.
      set_resp(16'd50, 16'd105, 7);
      p0 = pulse_cnt;
      g0 = gap_viol;
      pulse_start();
      chk("s2_locked_clr",  32'(locked),     32'd0);
      wait_idle("s2_idle", 400);
      chk("s2_locked",      32'(locked),     32'd1);
      chk("s2_sel_a",       32'(sel_a),      32'd3);
      chk("s2_sel_b",       32'(sel_b),      32'd1);
      chk("s2_result",      32'(result_cnt), 32'd105);
      chk("s2_pulses",      32'(pulse_cnt - p0), 32'd8);
      chk("s2_settle_gap",  32'(gap_viol - g0),  32'd0);

      // Exhaustion: every count rejected.
      set_resp(16'd0, 16'd0, 16);
      p0 = pulse_cnt;
      pulse_start();
      chk("s3_locked_clr",  32'(locked),     32'd0);
      wait_idle("s3_idle", 600);
      chk("s3_fail",        32'(fail),       32'd1);
      chk("s3_locked",      32'(locked),     32'd0);
      chk("s3_sel_a",       32'(sel_a),      32'd3);
      chk("s3_sel_b",       32'(sel_b),      32'd3);
      chk("s3_pulses",      32'(pulse_cnt - p0), 32'd16);

      // Inverted window accepts nothing.
      cnt_min = 16'd120;
      cnt_max = 16'd100;
      set_resp(16'd110, 16'd110, 0);
      p0 = pulse_cnt;
      pulse_start();
      chk("s4_fail_clr",    32'(fail),       32'd0);
      wait_idle("s4_idle", 600);
      chk("s4_fail",        32'(fail),       32'd1);
      chk("s4_locked",      32'(locked),     32'd0);
      chk("s4_pulses",      32'(pulse_cnt - p0), 32'd16);

      // Single-point window: both bounds inclusive.
      cnt_min = 16'd110;
      cnt_max = 16'd110;
      p0 = pulse_cnt;
      pulse_start();
      wait_idle("s5_idle", 100);
      chk("s5_locked",      32'(locked),     32'd1);
      chk("s5_fail",        32'(fail),       32'd0);
      chk("s5_pulses",      32'(pulse_cnt - p0), 32'd1);

      // Timeout on idx 0, hit on idx 1.
      cnt_min = 16'd100;
      cnt_max = 16'd120;
      set_resp(16'd110, 16'd110, 0);
      resp_on[0] = 1'b0;
      pulse_start();
      wait_mstart("s6_mstart", 20);
      tick(8);
      chk("s6_eval_sel",    32'(sel_a),      32'd0);
      chk("s6_tmo_result",  32'(result_cnt), 32'hFFFF);
      tick();
      chk("s6_next_idx",    32'(sel_a),      32'd1);
      wait_idle("s6_idle", 100);
      chk("s6_locked",      32'(locked),     32'd1);
      chk("s6_sel_a",       32'(sel_a),      32'd1);
      chk("s6_sel_b",       32'(sel_b),      32'd0);
      chk("s6_result",      32'(result_cnt), 32'd110);

      // Starts during APPLY and MEAS are ignored; start in LOCK restarts.
      set_resp(16'd50, 16'd105, 1);
      p0 = pulse_cnt;
      pulse_start();
      tick();
      pulse_start();
      wait_mstart("s7_mstart", 20);
      pulse_start();
      k = 0;
      while (sel_a != 2'd1 && k < 50) begin
         tick();
         k++;
      end
      chk("s7_reach_idx1",  32'(sel_a),      32'd1);
      pulse_start();
      wait_idle("s7_idle", 100);
      chk("s7_locked",      32'(locked),     32'd1);
      chk("s7_sel_a",       32'(sel_a),      32'd1);
      chk("s7_pulses",      32'(pulse_cnt - p0), 32'd2);
      pulse_start();
      chk("s7_relock_clr",  32'(locked),     32'd0);
      chk("s7_rebusy",      32'(busy),       32'd1);
      chk("s7_restart_idx", 32'(sel_a),      32'd0);
      wait_idle("s7_idle2", 100);
      chk("s7_relocked",    32'(sel_a),      32'd1);

      // Reset during MEAS of idx 2 with meas_done high on the reset edge.
      set_resp(16'd50, 16'd110, 2);
      pulse_start();
      k = 0;
      while (!(meas_start && sel_a == 2'd2) && k < 200) begin
         tick();
         k++;
      end
      chk("s8_reach_idx2",  32'(sel_a),      32'd2);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("s8_busy",        32'(busy),       32'd0);
      chk("s8_locked",      32'(locked),     32'd0);
      chk("s8_fail",        32'(fail),       32'd0);
      chk("s8_sel_a",       32'(sel_a),      32'd0);
      chk("s8_sel_b",       32'(sel_b),      32'd0);
      chk("s8_result",      32'(result_cnt), 32'd0);
      chk("s8_mstart",      32'(meas_start), 32'd0);
      p0 = pulse_cnt;
      tick(20);
      chk("s8_no_pulse",    32'(pulse_cnt - p0), 32'd0);
      chk("s8_still_idle",  32'(busy),       32'd0);
      set_resp(16'd110, 16'd110, 0);
      pulse_start();
      wait_mstart("s8_mstart2", 20);
      chk("s8_restart_a",   32'(sel_a),      32'd0);
      chk("s8_restart_b",   32'(sel_b),      32'd0);
      wait_idle("s8_idle", 100);
      chk("s8_relocked",    32'(locked),     32'd1);
      chk("s8_result2",     32'(result_cnt), 32'd110);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/ro_config_sweeper.md
RO_CONFIG_SWEEPER -- requirements
Module: ro_config_sweeper

Interface
REQ-001 SHALL have parameter NSTAGES, default 3: number of matched stages per ring; each stage takes a 2-bit select.
REQ-002 SHALL have parameter CNT_W, default 16: width of the measurement count.
REQ-003 SHALL have parameter SETTLE_CYC, default 16: number of clk cycles the rings settle after a configuration change.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 65535: maximum number of cycles to wait for meas_done.
REQ-005 SHALL have port clk, input, 1 bit: the single clock.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port start, input, 1 bit: single-cycle request to start a sweep.
REQ-008 SHALL have port meas_cnt, input, CNT_W bits: count reported by the coherent-sampling counter.
REQ-009 SHALL have port meas_done, input, 1 bit: single-cycle pulse; meas_cnt is valid in the same cycle.
REQ-010 SHALL have port cnt_min, input, CNT_W bits: lower bound of the acceptance window, inclusive.
REQ-011 SHALL have port cnt_max, input, CNT_W bits: upper bound of the acceptance window, inclusive.
REQ-012 SHALL have port sel_a, output, 2*NSTAGES bits: stage selects for ring A (stage k uses bits [2k+1:2k]).
REQ-013 SHALL have port sel_b, output, 2*NSTAGES bits: stage selects for ring B.
REQ-014 SHALL have port meas_start, output, 1 bit: single-cycle pulse requesting a measurement.
REQ-015 SHALL have port result_cnt, output, CNT_W bits: last captured count.
REQ-016 SHALL have port busy, output, 1 bit: high while a sweep is in progress.
REQ-017 SHALL have port locked, output, 1 bit: high when an accepted configuration is held.
REQ-018 SHALL have port fail, output, 1 bit: high when the full space was exhausted without acceptance.

Function
REQ-019 SHALL keep a configuration index idx of 4*NSTAGES bits; sel_a = idx[2N-1:0] and sel_b = idx[4N-1:2N], both registered.
REQ-020 SHALL implement the states IDLE, APPLY, MEAS, EVAL, LOCK and FAIL.
REQ-021 SHALL, on start in IDLE, LOCK or FAIL: set idx to 0, clear locked and fail, set busy, and enter APPLY on the next cycle.
REQ-022 SHALL ignore start while busy is high.
REQ-023 SHALL, in APPLY: have the sel outputs equal idx, count SETTLE_CYC cycles, then enter MEAS.
REQ-024 SHALL assert meas_start for exactly the first cycle of MEAS.
REQ-025 SHALL, in MEAS, sample meas_done in every cycle, including the meas_start cycle.
REQ-026 SHALL, on meas_done in MEAS: capture meas_cnt into result_cnt and enter EVAL.
REQ-027 SHALL, when TIMEOUT_CYC cycles elapse in MEAS without meas_done: load result_cnt with all-ones, set an internal timeout flag, and enter EVAL.
REQ-028 SHALL ignore meas_done outside MEAS.
REQ-029 SHALL, in EVAL (one cycle): if there is no timeout and cnt_min <= result_cnt <= cnt_max (unsigned), enter LOCK.
REQ-030 SHALL, in EVAL when not accepted and idx is all-ones, enter FAIL.
REQ-031 SHALL, in EVAL when not accepted and idx is not all-ones, increment idx and enter APPLY.
REQ-032 SHALL never let idx wrap to 0 within a sweep.
REQ-033 SHALL, in LOCK: set locked=1 and busy=0, and hold sel_a, sel_b and result_cnt stable until the next start or rst.
REQ-034 SHALL, in FAIL: set fail=1 and busy=0, and hold sel at the all-ones idx.
REQ-035 SHALL treat cnt_min > cnt_max as an empty window, so no configuration is accepted.
REQ-036 SHALL sample cnt_min and cnt_max only in EVAL.
REQ-037 SHALL keep locked and fail mutually exclusive at all times.

Reset
REQ-038 SHALL, on rst high at a clk edge, set state to IDLE and idx, sel_a, sel_b, result_cnt, meas_start, busy, locked, fail and all counters to 0.
REQ-039 SHALL give rst priority over start and meas_done in the same cycle.
REQ-040 SHALL abort a sweep in progress on reset, with no further meas_start pulse.

Verification
REQ-041 SHALL pass the first-hit scenario: NSTAGES=1, SETTLE_CYC=4, window [100,120], responder returns 110 two cycles after meas_start -> locked, sel_a=0, sel_b=0, result_cnt=110, exactly one meas_start pulse.
REQ-042 SHALL pass the mid-sweep hit scenario: NSTAGES=1, responder returns 50 for idx 0..6 and 105 for idx 7 -> locked, sel_a=2'b11, sel_b=2'b01, exactly 8 meas_start pulses, each at least 4 cycles after the corresponding sel change.
REQ-043 SHALL pass the exhaustion scenario: NSTAGES=1, responder always returns 0 -> 16 trials, then fail=1, busy=0, sel_a=sel_b=2'b11, locked=0.
REQ-044 SHALL pass the timeout scenario: TIMEOUT_CYC=8, no meas_done for idx 0, then 110 for idx 1 -> idx 0 rejected after 8 MEAS cycles, then locked at idx 1.
REQ-045 SHALL pass the reset-mid-MEAS scenario: rst asserted during MEAS while meas_done is high in the same cycle -> all outputs 0, state IDLE, no capture; a later start restarts the sweep at idx 0.
REQ-046 SHALL pass the ignored-start scenario: start pulsed during APPLY and during MEAS -> no restart, idx sequence unchanged; start in LOCK -> new sweep from idx 0 with locked cleared.
